// File: rtl/fsk_modulator.sv
// ---------------------------------------------------------------------------
// fsk_modulator
// Binary FSK modulator. Each accepted data bit becomes one symbol lasting
// SYM_LEN clk cycles. During the symbol a square-wave carrier is produced by
// integer division: period DIV0 for a 0 bit, DIV1 for a 1 bit. A bit arriving
// on the last cycle of a symbol continues the carrier phase across the boundary.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         enable; low returns to idle on the next edge
//   bit_in     data bit to send
//   bit_valid  bit_in is valid
//   bit_ready  bit is accepted this cycle (combinational)
//   fsk_out    modulated carrier (registered)
//   sym_bit    bit of the symbol being sent (registered)
//   sym_start  one-cycle pulse on the first cycle of each symbol (registered)
//   busy       high while a symbol is being sent (registered)
// ---------------------------------------------------------------------------
module fsk_modulator #(
    parameter int DIV0    = 32,
    parameter int DIV1    = 16,
    parameter int SYM_LEN = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_ready,
    output logic fsk_out,
    output logic sym_bit,
    output logic sym_start,
    output logic busy
);

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

    localparam logic [15:0] H0_LAST  = 16'(DIV0 / 2 - 1);
    localparam logic [15:0] H1_LAST  = 16'(DIV1 / 2 - 1);
    localparam logic [15:0] SYM_LAST = 16'(SYM_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] sym_cnt_q, sym_cnt_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic        fsk_out_q, fsk_out_d;
    logic        sym_bit_q, sym_bit_d;
    logic        sym_start_q, sym_start_d;
    logic        busy_q, busy_d;

    logic        sym_last;
    logic        half_last;
    logic        accept;
    logic        fsk_next;

    assign sym_last  = (sym_cnt_q == SYM_LAST);
    // Half period always follows the symbol currently on air, even on the
    // boundary edge where a new bit is being accepted.
    assign half_last = (half_cnt_q == (sym_bit_q ? H1_LAST : H0_LAST));
    assign bit_ready = en & ((state_q == IDLE) | ((state_q == TX) & sym_last));
    assign accept    = bit_valid & bit_ready;
    assign fsk_next  = half_last ? ~fsk_out_q : fsk_out_q;

    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        half_cnt_d  = half_cnt_q;
        fsk_out_d   = fsk_out_q;
        sym_bit_d   = sym_bit_q;
        sym_start_d = 1'b0;
        busy_d      = busy_q;

        if (!en) begin
            state_d    = IDLE;
            sym_cnt_d  = '0;
            half_cnt_d = '0;
            fsk_out_d  = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d     = TX;
                        sym_bit_d   = bit_in;
                        sym_cnt_d   = '0;
                        half_cnt_d  = '0;
                        fsk_out_d   = 1'b0;
                        sym_start_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                TX: begin
                    if (sym_last) begin
                        if (accept) begin
                            // Phase-continuous: a toggle due on this edge still happens.
                            sym_bit_d   = bit_in;
                            sym_cnt_d   = '0;
                            half_cnt_d  = '0;
                            fsk_out_d   = fsk_next;
                            sym_start_d = 1'b1;
                            busy_d      = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            sym_cnt_d  = '0;
                            half_cnt_d = '0;
                            fsk_out_d  = 1'b0;
                            busy_d     = 1'b0;
                        end
                    end else begin
                        sym_cnt_d  = sym_cnt_q + 16'd1;
                        half_cnt_d = half_last ? 16'd0 : half_cnt_q + 16'd1;
                        fsk_out_d  = fsk_next;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            half_cnt_q  <= '0;
            fsk_out_q   <= 1'b0;
            sym_bit_q   <= 1'b0;
            sym_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            half_cnt_q  <= half_cnt_d;
            fsk_out_q   <= fsk_out_d;
            sym_bit_q   <= sym_bit_d;
            sym_start_q <= sym_start_d;
            busy_q      <= busy_d;
        end
    end

    assign fsk_out   = fsk_out_q;
    assign sym_bit   = sym_bit_q;
    assign sym_start = sym_start_q;
    assign busy      = busy_q;

endmodule
